// File: rtl/pair_burst_gen.sv
// Two-signal burst stimulus source: drives aligned bursts on a/b with
// independent lengths, repeated with a forced low gap between bursts.
module pair_burst_gen #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] a_len,
    input  logic [CNT_W-1:0] b_len,
    input  logic [CNT_W-1:0] gap_len,
    input  logic [CNT_W-1:0] rep,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] burst_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_GAP
    } state_t;

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO = '0;

    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [CNT_W-1:0] r_acnt, w_acnt;
    logic [CNT_W-1:0] r_bcnt, w_bcnt;
    logic [CNT_W-1:0] r_a_sh, w_a_sh;
    logic [CNT_W-1:0] r_b_sh, w_b_sh;
    logic [CNT_W-1:0] r_len_sh, w_len_sh;
    logic [CNT_W-1:0] r_gap_sh, w_gap_sh;
    logic [CNT_W-1:0] r_rep_sh, w_rep_sh;
    logic [CNT_W-1:0] r_idx, w_idx;
    logic             r_a, w_a;
    logic             r_b, w_b;
    logic             r_busy, w_busy;
    logic             r_done, w_done;
    logic [CNT_W-1:0] w_max_ab;
    logic [CNT_W-1:0] w_len_in;

    assign w_max_ab = (a_len > b_len) ? a_len : b_len;
    assign w_len_in = (w_max_ab == ZERO) ? ONE : w_max_ab;

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_acnt   = r_acnt;
        w_bcnt   = r_bcnt;
        w_a_sh   = r_a_sh;
        w_b_sh   = r_b_sh;
        w_len_sh = r_len_sh;
        w_gap_sh = r_gap_sh;
        w_rep_sh = r_rep_sh;
        w_idx    = r_idx;
        w_a      = r_a;
        w_b      = r_b;
        w_busy   = r_busy;
        w_done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_a_sh   = a_len;
                    w_b_sh   = b_len;
                    w_len_sh = w_len_in;
                    w_gap_sh = (gap_len == ZERO) ? ONE : gap_len;
                    w_rep_sh = (rep == ZERO) ? ONE : rep;
                    w_state  = S_BURST;
                    w_cnt    = w_len_in;
                    w_acnt   = a_len;
                    w_bcnt   = b_len;
                    w_a      = (a_len != ZERO);
                    w_b      = (b_len != ZERO);
                    w_busy   = 1'b1;
                    w_idx    = ZERO;
                end
            end
            S_BURST: begin
                if (r_cnt == ONE) begin
                    w_a    = 1'b0;
                    w_b    = 1'b0;
                    w_acnt = ZERO;
                    w_bcnt = ZERO;
                    if (r_idx == r_rep_sh - ONE) begin
                        w_state = S_IDLE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end else begin
                        w_state = S_GAP;
                        w_cnt   = r_gap_sh;
                    end
                end else begin
                    // acnt/bcnt hold the high cycles left including this one
                    w_cnt  = r_cnt - ONE;
                    w_a    = (r_acnt > ONE);
                    w_b    = (r_bcnt > ONE);
                    w_acnt = (r_acnt == ZERO) ? ZERO : r_acnt - ONE;
                    w_bcnt = (r_bcnt == ZERO) ? ZERO : r_bcnt - ONE;
                end
            end
            S_GAP: begin
                if (r_cnt == ONE) begin
                    w_state = S_BURST;
                    w_cnt   = r_len_sh;
                    w_acnt  = r_a_sh;
                    w_bcnt  = r_b_sh;
                    w_a     = (r_a_sh != ZERO);
                    w_b     = (r_b_sh != ZERO);
                    w_idx   = r_idx + ONE;
                end else begin
                    w_cnt = r_cnt - ONE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acnt   <= '0;
            r_bcnt   <= '0;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_len_sh <= '0;
            r_gap_sh <= '0;
            r_rep_sh <= '0;
            r_idx    <= '0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_acnt   <= w_acnt;
            r_bcnt   <= w_bcnt;
            r_a_sh   <= w_a_sh;
            r_b_sh   <= w_b_sh;
            r_len_sh <= w_len_sh;
            r_gap_sh <= w_gap_sh;
            r_rep_sh <= w_rep_sh;
            r_idx    <= w_idx;
            r_a      <= w_a;
            r_b      <= w_b;
            r_busy   <= w_busy;
            r_done   <= w_done;
        end
    end

    assign a         = r_a;
    assign b         = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign burst_idx = r_idx;

endmodule

// File: doc/pair_burst_gen.md
# pair_burst_gen

Synchronous stimulus source for the two-signal burst patterns our concurrent-assertion checkers consume: on a start request it drives a burst on `a` and a burst on `b`, both rising on the same edge and each held for its own programmed length. The burst repeats a programmed number of times with a forced idle gap between bursts. It is the driving end of the `a`/`b` interface that the `$rose(a) |-> a[*N] iff b[*M]` style properties sample, so benches can produce matching and mismatching patterns from RTL instead of hand-written initial blocks.

## Interface
- `CNT_W`, default 4: width of every length, gap and repeat field and of the internal counters.
- `clk`  input  1  rising-edge clock; all state changes on posedge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only while idle.
- `a_len`  input  CNT_W  cycles `a` is held high per burst; 0 means `a` never asserts.
- `b_len`  input  CNT_W  cycles `b` is held high per burst; 0 means `b` never asserts.
- `gap_len`  input  CNT_W  low cycles between bursts; 0 is treated as 1.
- `rep`  input  CNT_W  number of bursts; 0 is treated as 1.
- `a`  output  1  burst signal A, registered.
- `b`  output  1  burst signal B, registered.
- `busy`  output  1  high while a sequence is in progress.
- `done`  output  1  one-cycle pulse after the final burst.
- `burst_idx`  output  CNT_W  zero-based index of the current burst; holds its last value when idle.

## Operation
- States: IDLE, BURST, GAP.
- **IDLE**
  - `start`=1 latches `a_len`, `b_len`, `gap_len` and `rep` into shadow registers.
  - Input changes after that edge have no effect on the running sequence.
  - Transition to BURST; clear `burst_idx` to 0.
- **BURST** lasts L = max(a_len, b_len, 1) cycles, counted by a down-counter.
  - `a` is high for the first a_len of those cycles.
  - `b` is high for the first b_len of those cycles.
  - On the last cycle: if `burst_idx` = rep_eff−1, go to IDLE and pulse `done`. Otherwise go to GAP.
- **GAP** lasts G = max(gap_len, 1) cycles with `a`=`b`=0.
  - Then go to BURST and increment `burst_idx`.
  - The mandatory low cycle guarantees every burst presents a fresh `$rose`.
- `start` in BURST or GAP is ignored; it is neither queued nor restarts the sequence.
- `start` in the cycle where `done`=1 is accepted, because the block is already in IDLE.
- Both lengths 0: a 1-cycle BURST with `a`=`b`=0. Timing, `busy` and `done` are otherwise unchanged.
- Counters are CNT_W bits. A maximum value of 2^CNT_W−1 is legal, and no counter wraps during a sequence.

## Timing
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `burst_idx`=0, state IDLE.
- Reset mid-sequence forces all outputs to their reset values on the next edge. No `done` is generated.
- `start` sampled high at edge T (idle): `a`/`b` (for nonzero lengths) and `busy` are high from T+1.
- Burst k (zero-based) starts at cycle T+1+k·(L+G).
- `a` falls at burst start + a_len; `b` falls at burst start + b_len.
- Final burst ends at cycle E = T + rep_eff·L + (rep_eff−1)·G.
  - `done`=1 and `busy`=0 in cycle E+1.
  - `done` is 0 again in cycle E+2 unless a new sequence completes.
- `busy` stays high through GAP cycles.
- All outputs come directly from flops; there is no combinational path from any input to any output.

## Test plan
- Single burst: `a_len`=2, `b_len`=3, `rep`=1, `start` pulse at edge 1.
  - `a` high in cycles 2–3; `b` high in cycles 2–4.
  - `busy` high in cycles 2–4; `done` high in cycle 5 only.
- Repeat with gap: `a_len`=`b_len`=2, `gap_len`=0, `rep`=3, `start` at edge 1.
  - `a`/`b` high in cycles 2–3, 5–6 and 8–9, each burst separated by one low cycle.
  - `burst_idx` reads 0, 1, 2 across the bursts; `done` in cycle 10.
- Zero lengths: `a_len`=0, `b_len`=4, `rep`=2, `gap_len`=2, `start` at edge 1.
  - `a` never rises; `b` high in cycles 2–5 and 8–11; `done` in cycle 12.
  - Separately, `a_len`=`b_len`=0, `rep`=1, `start` at edge 1: `a`/`b` stay low, `busy` high in cycle 2, `done` in cycle 3.
- Start handling: a second `start` at edge 3 while busy is ignored, and changing `a_len` mid-sequence has no effect.
  - `start` held high through the `done` cycle launches a new sequence whose burst begins in the cycle after `done`.
- Reset mid-burst: assert `rst` during BURST.
  - All outputs are 0 on the next edge, there is no `done` pulse, and a later `start` behaves normally.
- Max length: `CNT_W`=4, `a_len`=15, `b_len`=15, `rep`=15, `gap_len`=15.
  - Each burst is exactly 15 cycles with no counter wrap; `burst_idx` ends at 14.
